// File: rtl/vga_timing_pkg.sv
// Shared timing sets and helpers for the parametrised VGA timing generator.
package vga_timing_pkg;

    // Lengths of the four segments of one axis, in pixels or lines.
    typedef struct packed {
        int sync;
        int bp;
        int active;
        int fp;
    } axis_t;

    // A complete video mode: both axes plus the asserted sync levels.
    typedef struct packed {
        axis_t h;
        axis_t v;
        logic  hs_pol;
        logic  vs_pol;
    } mode_t;

    localparam mode_t VGA_640x480_60 = '{
        h: '{96, 48, 640, 16},
        v: '{2, 29, 480, 10},
        hs_pol: 1'b0,
        vs_pol: 1'b0
    };

    localparam mode_t SVGA_800x600_60 = '{
        h: '{128, 88, 800, 40},
        v: '{4, 23, 600, 1},
        hs_pol: 1'b1,
        vs_pol: 1'b1
    };

    // Total period of one axis (pixels per line or lines per frame).
    function automatic int axis_total(int sync, int bp, int active, int fp);
        return sync + bp + active + fp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the timing generator: a wrapping counter that parks at its last
// value, plus sync/active decode of the value it will hold after this edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          park,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] next_cnt,
    output logic          wrap,
    output logic          in_sync,
    output logic          in_active
);

    localparam int            TOTAL     = axis_total(SYNC, BP, ACTIVE, FP);
    localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_END  = CW'(SYNC);
    localparam logic [CW-1:0] ACT_FIRST = CW'(SYNC + BP);
    localparam logic [CW-1:0] ACT_LAST  = CW'(SYNC + BP + ACTIVE - 1);

    // Terminal count: a step taken now wraps the axis back to zero.
    assign wrap = (cnt == LAST);

    // Next counter value; park wins over step so the axis restarts cleanly.
    always_comb begin
        // NOTE: default first so every path assigns next_cnt and no latch is inferred.
        next_cnt = cnt;
        if (park) begin
            next_cnt = LAST;
        end else if (step) begin
            next_cnt = wrap ? '0 : cnt + CW'(1);
        end
    end

    // Decode the value the counter is about to take, so registered outputs line up with cnt.
    assign in_sync   = (next_cnt < SYNC_END);
    assign in_active = (next_cnt >= ACT_FIRST) && (next_cnt <= ACT_LAST);

    // Counter register; resets into the parked position.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (!rst_n) begin
            cnt <= LAST;
        end else begin
            cnt <= next_cnt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator with pixel-clock enable, run/park
// control, active-area coordinates and line/frame strobes. Every output is a
// register loaded from the next counter values, so all outputs move together.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CW       = 10,
    parameter int   H_SYNC   = VGA_640x480_60.h.sync,
    parameter int   H_BP     = VGA_640x480_60.h.bp,
    parameter int   H_ACTIVE = VGA_640x480_60.h.active,
    parameter int   H_FP     = VGA_640x480_60.h.fp,
    parameter int   V_SYNC   = VGA_640x480_60.v.sync,
    parameter int   V_BP     = VGA_640x480_60.v.bp,
    parameter int   V_ACTIVE = VGA_640x480_60.v.active,
    parameter int   V_FP     = VGA_640x480_60.v.fp,
    parameter logic HS_POL   = VGA_640x480_60.hs_pol,
    parameter logic VS_POL   = VGA_640x480_60.vs_pol
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    input  logic          run,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic          vidon,
    output logic [CW-1:0] px_x,
    output logic [CW-1:0] px_y,
    output logic          vblank,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

    localparam logic [CW-1:0] PX_OFF = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] PY_OFF = CW'(V_SYNC + V_BP);

    // Refuse to build a generator whose counters cannot hold a full line or frame.
    if (H_TOTAL > 2**CW) begin : g_h_too_wide
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > 2**CW) begin : g_v_too_wide
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end

    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          h_in_active;
    logic          v_in_active;
    logic          park;
    logic          tick;
    logic          vid_next;

    assign park     = ~run;
    assign tick     = run & pix_en;
    assign vid_next = run & h_in_active & v_in_active;

    vga_axis_counter #(
        .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CW(CW)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step(pix_en), .park(park),
        .cnt(hc), .next_cnt(h_next), .wrap(h_wrap),
        .in_sync(h_in_sync), .in_active(h_in_active)
    );

    vga_axis_counter #(
        .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CW(CW)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step(pix_en & h_wrap), .park(park),
        .cnt(vc), .next_cnt(v_next), .wrap(v_wrap),
        .in_sync(v_in_sync), .in_active(v_in_active)
    );

    // Registered decode with polarity applied; parked values on reset or run=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            vidon       <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            vblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (run && h_in_sync) ? HS_POL : ~HS_POL;
            vsync       <= (run && v_in_sync) ? VS_POL : ~VS_POL;
            vidon       <= vid_next;
            px_x        <= vid_next ? (h_next - PX_OFF) : '0;
            px_y        <= vid_next ? (v_next - PY_OFF) : '0;
            vblank      <= ~(run & v_in_active);
            line_start  <= tick & h_wrap;
            frame_start <= tick & h_wrap & v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 640x480 instance, an
// 800x600 instance with positive syncs, and a tiny instance for whole-frame
// periods, last-active-pixel and run/park behaviour.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef enum int { F_HC, F_VC, F_PX, F_PY, F_HS, F_VS, F_VID, F_VBL, F_LS, F_FS } field_e;

    typedef struct {
        int hc, vc, px, py;
        logic hs, vs, vid, vbl, ls, fs;
    } obs_t;

    typedef struct {
        int     at_cyc;
        int     dut;
        field_e f;
        int     exp;
        string  name;
    } sb_entry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    sb_entry_t sb [$];
    sb_entry_t cur;

    // DUT 0: default 640x480
    logic       d_rst_n, d_pix, d_run;
    logic       d_hs, d_vs, d_vid, d_vbl, d_ls, d_fs;
    logic [9:0] d_hc, d_vc, d_px, d_py;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(d_rst_n), .pix_en(d_pix), .run(d_run),
        .hsync(d_hs), .vsync(d_vs), .hc(d_hc), .vc(d_vc), .vidon(d_vid),
        .px_x(d_px), .px_y(d_py), .vblank(d_vbl),
        .line_start(d_ls), .frame_start(d_fs)
    );

    // DUT 1: 800x600, positive syncs
    logic        s_rst_n, s_pix, s_run;
    logic        s_hs, s_vs, s_vid, s_vbl, s_ls, s_fs;
    logic [10:0] s_hc, s_vc, s_px, s_py;

    vga_timing_gen #(
        .CW(11),
        .H_SYNC(SVGA_800x600_60.h.sync), .H_BP(SVGA_800x600_60.h.bp),
        .H_ACTIVE(SVGA_800x600_60.h.active), .H_FP(SVGA_800x600_60.h.fp),
        .V_SYNC(SVGA_800x600_60.v.sync), .V_BP(SVGA_800x600_60.v.bp),
        .V_ACTIVE(SVGA_800x600_60.v.active), .V_FP(SVGA_800x600_60.v.fp),
        .HS_POL(SVGA_800x600_60.hs_pol), .VS_POL(SVGA_800x600_60.vs_pol)
    ) u_svga (
        .clk(clk), .rst_n(s_rst_n), .pix_en(s_pix), .run(s_run),
        .hsync(s_hs), .vsync(s_vs), .hc(s_hc), .vc(s_vc), .vidon(s_vid),
        .px_x(s_px), .px_y(s_py), .vblank(s_vbl),
        .line_start(s_ls), .frame_start(s_fs)
    );

    // DUT 2: tiny mode, H 4/3/8/2 = 17, V 2/2/5/1 = 10
    logic       m_rst_n, m_pix, m_run;
    logic       m_hs, m_vs, m_vid, m_vbl, m_ls, m_fs;
    logic [5:0] m_hc, m_vc, m_px, m_py;

    vga_timing_gen #(
        .CW(6),
        .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(m_rst_n), .pix_en(m_pix), .run(m_run),
        .hsync(m_hs), .vsync(m_vs), .hc(m_hc), .vc(m_vc), .vidon(m_vid),
        .px_x(m_px), .px_y(m_py), .vblank(m_vbl),
        .line_start(m_ls), .frame_start(m_fs)
    );

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic obs_t mk(int hc, int vc, int px, int py,
                                logic hs, logic vs, logic vid, logic vbl, logic ls, logic fs);
        obs_t o;
        o.hc = hc; o.vc = vc; o.px = px; o.py = py;
        o.hs = hs; o.vs = vs; o.vid = vid; o.vbl = vbl; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic obs_t sample(int d);
        case (d)
            0:       return mk(int'(d_hc), int'(d_vc), int'(d_px), int'(d_py), d_hs, d_vs, d_vid, d_vbl, d_ls, d_fs);
            1:       return mk(int'(s_hc), int'(s_vc), int'(s_px), int'(s_py), s_hs, s_vs, s_vid, s_vbl, s_ls, s_fs);
            default: return mk(int'(m_hc), int'(m_vc), int'(m_px), int'(m_py), m_hs, m_vs, m_vid, m_vbl, m_ls, m_fs);
        endcase
    endfunction

    function automatic int pick(obs_t o, field_e f);
        case (f)
            F_HC:    return o.hc;
            F_VC:    return o.vc;
            F_PX:    return o.px;
            F_PY:    return o.py;
            F_HS:    return int'(o.hs);
            F_VS:    return int'(o.vs);
            F_VID:   return int'(o.vid);
            F_VBL:   return int'(o.vbl);
            F_LS:    return int'(o.ls);
            default: return int'(o.fs);
        endcase
    endfunction

    // Monitor: pop every expectation due this cycle and compare mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.at_cyc == cyc) check(cur.name, pick(sample(cur.dut), cur.f), cur.exp);
            else check({cur.name, "_stale"}, -1, cur.exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation for the state visible during the current cycle.
    task automatic ex(int d, field_e f, int v);
        sb.push_back('{cyc, d, f, v, $sformatf("dut%0d_cyc%0d_%s", d, cyc, f.name())});
    endtask

    task automatic ex_park(int d, int hl, int vl, int hs, int vs);
        ex(d, F_HC, hl); ex(d, F_VC, vl); ex(d, F_HS, hs); ex(d, F_VS, vs);
        ex(d, F_VID, 0); ex(d, F_PX, 0); ex(d, F_PY, 0); ex(d, F_VBL, 1);
        ex(d, F_LS, 0); ex(d, F_FS, 0);
    endtask

    initial begin
        d_rst_n = 1'b0; d_pix = 1'b0; d_run = 1'b0;
        s_rst_n = 1'b0; s_pix = 1'b0; s_run = 1'b0;
        m_rst_n = 1'b0; m_pix = 1'b0; m_run = 1'b0;
        repeat (3) step();
        d_rst_n = 1'b1; s_rst_n = 1'b1; m_rst_n = 1'b1;
        step();
        ex_park(0, 799, 520, 1, 1);
        ex_park(1, 1055, 627, 0, 0);
        ex_park(2, 16, 9, 1, 1);

        // Default mode, pixel tick every clock.
        d_run = 1'b1; d_pix = 1'b1;
        for (int k = 1; k <= 25901; k++) begin
            step();
            case (k - 1)
                0: begin
                    ex(0, F_HC, 0); ex(0, F_VC, 0); ex(0, F_FS, 1); ex(0, F_LS, 1);
                    ex(0, F_HS, 0); ex(0, F_VS, 0); ex(0, F_VBL, 1); ex(0, F_VID, 0);
                end
                1:     begin ex(0, F_HC, 1); ex(0, F_FS, 0); ex(0, F_LS, 0); end
                95:    ex(0, F_HS, 0);
                96:    begin ex(0, F_HS, 1); ex(0, F_HC, 96); end
                799:   begin ex(0, F_HC, 799); ex(0, F_VC, 0); end
                800:   begin ex(0, F_HC, 0); ex(0, F_VC, 1); ex(0, F_LS, 1); ex(0, F_FS, 0); end
                1599:  ex(0, F_VS, 0);
                1600:  begin ex(0, F_VS, 1); ex(0, F_VC, 2); end
                24799: begin ex(0, F_VBL, 1); ex(0, F_VC, 30); end
                24943: begin ex(0, F_VID, 0); ex(0, F_VBL, 0); ex(0, F_HC, 143); ex(0, F_VC, 31); end
                24944: begin
                    ex(0, F_VID, 1); ex(0, F_PX, 0); ex(0, F_PY, 0);
                    ex(0, F_HC, 144); ex(0, F_VC, 31);
                end
                25583: begin ex(0, F_VID, 1); ex(0, F_PX, 639); ex(0, F_PY, 0); ex(0, F_HC, 783); end
                25584: begin ex(0, F_VID, 0); ex(0, F_PX, 0); end
                25900: begin
                    ex(0, F_HC, 300); ex(0, F_VC, 32); ex(0, F_VID, 1);
                    ex(0, F_PX, 156); ex(0, F_PY, 1);
                end
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of an active line.
        @(negedge clk);
        #1 d_rst_n = 1'b0;
        #1;
        check("async_rst_hc", int'(d_hc), 799);
        check("async_rst_vc", int'(d_vc), 520);
        check("async_rst_hsync", int'(d_hs), 1);
        check("async_rst_vidon", int'(d_vid), 0);
        check("async_rst_px_x", int'(d_px), 0);
        check("async_rst_vblank", int'(d_vbl), 1);

        d_run = 1'b0; d_pix = 1'b0;
        step();
        d_rst_n = 1'b1;
        step();
        ex(0, F_HC, 799);

        // Pixel tick on alternate clocks: 1600 clocks per line, outputs hold between ticks.
        d_run = 1'b1; d_pix = 1'b1;
        for (int k = 1; k <= 1602; k++) begin
            step();
            case (k)
                1:    begin ex(0, F_HC, 0); ex(0, F_VC, 0); ex(0, F_FS, 1); ex(0, F_LS, 1); end
                2:    begin ex(0, F_HC, 0); ex(0, F_FS, 0); ex(0, F_LS, 0); end
                3:    ex(0, F_HC, 1);
                4:    ex(0, F_HC, 1);
                1600: begin ex(0, F_HC, 799); ex(0, F_VC, 0); ex(0, F_LS, 0); end
                1601: begin ex(0, F_HC, 0); ex(0, F_VC, 1); ex(0, F_LS, 1); end
                1602: begin ex(0, F_HC, 0); ex(0, F_LS, 0); end
                default: ;
            endcase
            d_pix = (k % 2 == 0);
        end
        d_run = 1'b0;

        // Tiny mode: whole-frame period, last active pixel, park and restart.
        m_run = 1'b1; m_pix = 1'b1;
        for (int k = 1; k <= 275; k++) begin
            step();
            case (k)
                1:   begin ex(2, F_FS, 1); ex(2, F_LS, 1); ex(2, F_HC, 0); ex(2, F_VC, 0); end
                2:   begin ex(2, F_FS, 0); ex(2, F_LS, 0); end
                17:  begin ex(2, F_HC, 16); ex(2, F_VC, 0); ex(2, F_LS, 0); end
                18:  begin ex(2, F_HC, 0); ex(2, F_VC, 1); ex(2, F_LS, 1); ex(2, F_FS, 0); end
                34:  ex(2, F_VS, 0);
                35:  begin ex(2, F_VS, 1); ex(2, F_VC, 2); ex(2, F_HC, 0); end
                75:  ex(2, F_VID, 0);
                76:  begin ex(2, F_VID, 1); ex(2, F_PX, 0); ex(2, F_PY, 0); ex(2, F_HC, 7); ex(2, F_VC, 4); end
                151: begin
                    ex(2, F_VID, 1); ex(2, F_PX, 7); ex(2, F_PY, 4);
                    ex(2, F_HC, 14); ex(2, F_VC, 8); ex(2, F_VBL, 0);
                end
                152: begin ex(2, F_VID, 0); ex(2, F_PX, 0); ex(2, F_PY, 0); end
                153: begin ex(2, F_VBL, 0); ex(2, F_HC, 16); ex(2, F_VC, 8); end
                154: begin ex(2, F_VBL, 1); ex(2, F_VC, 9); ex(2, F_HC, 0); end
                170: begin ex(2, F_FS, 0); ex(2, F_HC, 16); ex(2, F_VC, 9); end
                171: begin ex(2, F_FS, 1); ex(2, F_LS, 1); ex(2, F_HC, 0); ex(2, F_VC, 0); end
                172: ex(2, F_FS, 0);
                266: begin
                    ex(2, F_HC, 10); ex(2, F_VC, 5); ex(2, F_VID, 1);
                    ex(2, F_PX, 3); ex(2, F_PY, 1);
                    m_run = 1'b0;
                end
                267, 268: ex_park(2, 16, 9, 1, 1);
                269: begin ex_park(2, 16, 9, 1, 1); m_run = 1'b1; end
                270: begin ex(2, F_HC, 0); ex(2, F_VC, 0); ex(2, F_FS, 1); ex(2, F_LS, 1); end
                271: begin ex(2, F_HC, 1); ex(2, F_FS, 0); ex(2, F_LS, 0); end
                default: ;
            endcase
        end
        m_run = 1'b0;

        // 800x600 with positive syncs.
        s_run = 1'b1; s_pix = 1'b1;
        for (int k = 1; k <= 28729; k++) begin
            step();
            case (k - 1)
                0:     begin ex(1, F_HS, 1); ex(1, F_VS, 1); ex(1, F_HC, 0); ex(1, F_VC, 0); ex(1, F_FS, 1); end
                127:   begin ex(1, F_HS, 1); ex(1, F_HC, 127); end
                128:   ex(1, F_HS, 0);
                1055:  begin ex(1, F_HC, 1055); ex(1, F_VC, 0); end
                1056:  begin ex(1, F_HC, 0); ex(1, F_VC, 1); ex(1, F_LS, 1); end
                4223:  begin ex(1, F_VS, 1); ex(1, F_VC, 3); end
                4224:  begin ex(1, F_VS, 0); ex(1, F_VC, 4); end
                28727: begin ex(1, F_VID, 0); ex(1, F_HC, 215); ex(1, F_VC, 27); end
                28728: begin
                    ex(1, F_VID, 1); ex(1, F_HC, 216); ex(1, F_VC, 27);
                    ex(1, F_PX, 0); ex(1, F_PY, 0); ex(1, F_VBL, 0);
                end
                default: ;
            endcase
        end
        s_run = 1'b0;
        step();
        ex_park(1, 1055, 627, 0, 0);

        repeat (3) step();
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
